// File: rtl/rob_pkg.sv
// rob_pkg: shared widths, pointer and entry types for the reorder buffer.
//   ROB_SIZE      entry count (power of two, >= 4)
//   ROB_SIZE_LOG  index width
//   PC_W/LREG_W/PREG_W  payload field widths
package rob_pkg;
    localparam int ROB_SIZE     = 64;
    localparam int ROB_SIZE_LOG = $clog2(ROB_SIZE);
    localparam int PC_W         = 48;
    localparam int LREG_W       = 5;
    localparam int PREG_W       = 7;

    typedef struct packed {
        logic                    flag;
        logic [ROB_SIZE_LOG-1:0] idx;
    } rob_ptr_t;

    typedef struct packed {
        logic              valid;
        logic              complete;
        logic [PC_W-1:0]   pc;
        logic [LREG_W-1:0] lrd;
        logic [PREG_W-1:0] prd;
        logic [PREG_W-1:0] old_prd;
        logic              need_to_wb;
    } rob_entry_t;
endpackage

// File: rtl/rob_ptr_add.sv
// rob_ptr_add: adds 0..2 to a {flag, idx} ROB pointer, toggling flag on wrap.
//   ptr  in   pointer to advance
//   inc  in   increment, 0..2
//   sum  out  advanced pointer
module rob_ptr_add
    import rob_pkg::*;
(
    input  rob_ptr_t   ptr,
    input  logic [1:0] inc,
    output rob_ptr_t   sum
);
    // The flag is the carry out of idx, so a plain add over {flag, idx} wraps correctly.
    assign sum = rob_ptr_t'({ptr.flag, ptr.idx} + {{(ROB_SIZE_LOG-1){1'b0}}, inc});
endmodule

// File: rtl/reorder_buffer.sv
// reorder_buffer: two-lane in-order retirement buffer between dispatch and rename commit.
//   clock, reset_n                 clock and asynchronous active-low reset
//   enqN_valid/ready, enqN_*       dispatch enqueue lanes (lane1 only with lane0)
//   counter, enq_robidx(_flag)     occupancy and enqueue pointer stamped by dispatch
//   wbK_valid, wbK_robidx          writeback completion marks
//   commitN_valid, commitN_*       up to two oldest completed entries retired per cycle
//   flush_valid                    discard every entry and rewind both pointers
module reorder_buffer #(
    parameter int ROB_SIZE     = rob_pkg::ROB_SIZE,
    parameter int ROB_SIZE_LOG = $clog2(ROB_SIZE)
) (
    input  logic                        clock,
    input  logic                        reset_n,
    input  logic                        enq0_valid,
    input  logic                        enq1_valid,
    output logic                        enq0_ready,
    output logic                        enq1_ready,
    input  logic [rob_pkg::PC_W-1:0]    enq0_pc,
    input  logic [rob_pkg::LREG_W-1:0]  enq0_lrd,
    input  logic [rob_pkg::PREG_W-1:0]  enq0_prd,
    input  logic [rob_pkg::PREG_W-1:0]  enq0_old_prd,
    input  logic                        enq0_need_to_wb,
    input  logic [rob_pkg::PC_W-1:0]    enq1_pc,
    input  logic [rob_pkg::LREG_W-1:0]  enq1_lrd,
    input  logic [rob_pkg::PREG_W-1:0]  enq1_prd,
    input  logic [rob_pkg::PREG_W-1:0]  enq1_old_prd,
    input  logic                        enq1_need_to_wb,
    output logic [ROB_SIZE_LOG:0]       counter,
    output logic                        enq_robidx_flag,
    output logic [ROB_SIZE_LOG-1:0]     enq_robidx,
    input  logic                        wb0_valid,
    input  logic [ROB_SIZE_LOG-1:0]     wb0_robidx,
    input  logic                        wb1_valid,
    input  logic [ROB_SIZE_LOG-1:0]     wb1_robidx,
    output logic                        commit0_valid,
    output logic [rob_pkg::PC_W-1:0]    commit0_pc,
    output logic [rob_pkg::LREG_W-1:0]  commit0_lrd,
    output logic [rob_pkg::PREG_W-1:0]  commit0_prd,
    output logic [rob_pkg::PREG_W-1:0]  commit0_old_prd,
    output logic                        commit0_need_to_wb,
    output logic                        commit1_valid,
    output logic [rob_pkg::PC_W-1:0]    commit1_pc,
    output logic [rob_pkg::LREG_W-1:0]  commit1_lrd,
    output logic [rob_pkg::PREG_W-1:0]  commit1_prd,
    output logic [rob_pkg::PREG_W-1:0]  commit1_old_prd,
    output logic                        commit1_need_to_wb,
    input  logic                        flush_valid
);
    import rob_pkg::*;

    localparam logic [ROB_SIZE_LOG:0] ENQ_LIMIT = (ROB_SIZE_LOG+1)'(ROB_SIZE - 2);

    rob_entry_t          entries [ROB_SIZE];
    rob_entry_t          head0, head1;
    rob_ptr_t            enq_ptr, enq_ptr1, enq_ptr_nxt;
    rob_ptr_t            deq_ptr, deq_ptr1, deq_ptr_nxt;
    logic                ready, enq0_fire, enq1_fire, c0, c1;
    logic [1:0]          enq_cnt, deq_cnt;
    logic [ROB_SIZE_LOG:0] counter_nxt;

    rob_ptr_add u_enq_ptr1 (.ptr(enq_ptr), .inc(2'd1),    .sum(enq_ptr1));
    rob_ptr_add u_enq_nxt  (.ptr(enq_ptr), .inc(enq_cnt), .sum(enq_ptr_nxt));
    rob_ptr_add u_deq_ptr1 (.ptr(deq_ptr), .inc(2'd1),    .sum(deq_ptr1));
    rob_ptr_add u_deq_nxt  (.ptr(deq_ptr), .inc(deq_cnt), .sum(deq_ptr_nxt));

    // Readiness ignores same-cycle commits so an enqueue can never land on a retiring slot.
    assign ready      = reset_n && !flush_valid && (counter <= ENQ_LIMIT);
    assign enq0_ready = ready;
    assign enq1_ready = ready;
    assign enq0_fire  = enq0_valid && ready;
    assign enq1_fire  = enq1_valid && enq0_valid && ready;
    assign enq_cnt    = enq1_fire ? 2'd2 : (enq0_fire ? 2'd1 : 2'd0);

    assign head0   = entries[deq_ptr.idx];
    assign head1   = entries[deq_ptr1.idx];
    assign c0      = !flush_valid && head0.valid && head0.complete;
    assign c1      = c0 && head1.valid && head1.complete;
    assign deq_cnt = c1 ? 2'd2 : (c0 ? 2'd1 : 2'd0);

    assign counter_nxt = counter + (ROB_SIZE_LOG+1)'(enq_cnt) - (ROB_SIZE_LOG+1)'(deq_cnt);

    assign enq_robidx_flag = enq_ptr.flag;
    assign enq_robidx      = enq_ptr.idx;

    // Payload is gated by the lane valid so idle and reset outputs read as zero.
    assign commit0_valid      = c0;
    assign commit0_pc         = c0 ? head0.pc : '0;
    assign commit0_lrd        = c0 ? head0.lrd : '0;
    assign commit0_prd        = c0 ? head0.prd : '0;
    assign commit0_old_prd    = c0 ? head0.old_prd : '0;
    assign commit0_need_to_wb = c0 && head0.need_to_wb;
    assign commit1_valid      = c1;
    assign commit1_pc         = c1 ? head1.pc : '0;
    assign commit1_lrd        = c1 ? head1.lrd : '0;
    assign commit1_prd        = c1 ? head1.prd : '0;
    assign commit1_old_prd    = c1 ? head1.old_prd : '0;
    assign commit1_need_to_wb = c1 && head1.need_to_wb;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            enq_ptr <= '0;
            deq_ptr <= '0;
            counter <= '0;
        end else if (flush_valid) begin
            enq_ptr <= '0;
            deq_ptr <= '0;
            counter <= '0;
        end else begin
            enq_ptr <= enq_ptr_nxt;
            deq_ptr <= deq_ptr_nxt;
            counter <= counter_nxt;
        end
    end

    // Later assignments win: retirement clears a same-cycle writeback, enqueue rewrites last.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < ROB_SIZE; i++) entries[i] <= '0;
        end else if (flush_valid) begin
            for (int i = 0; i < ROB_SIZE; i++) begin
                entries[i].valid    <= 1'b0;
                entries[i].complete <= 1'b0;
            end
        end else begin
            if (wb0_valid && entries[wb0_robidx].valid) entries[wb0_robidx].complete <= 1'b1;
            if (wb1_valid && entries[wb1_robidx].valid) entries[wb1_robidx].complete <= 1'b1;
            if (c0) begin
                entries[deq_ptr.idx].valid    <= 1'b0;
                entries[deq_ptr.idx].complete <= 1'b0;
            end
            if (c1) begin
                entries[deq_ptr1.idx].valid    <= 1'b0;
                entries[deq_ptr1.idx].complete <= 1'b0;
            end
            if (enq0_fire)
                entries[enq_ptr.idx] <= '{valid: 1'b1, complete: 1'b0, pc: enq0_pc, lrd: enq0_lrd,
                                          prd: enq0_prd, old_prd: enq0_old_prd, need_to_wb: enq0_need_to_wb};
            if (enq1_fire)
                entries[enq_ptr1.idx] <= '{valid: 1'b1, complete: 1'b0, pc: enq1_pc, lrd: enq1_lrd,
                                           prd: enq1_prd, old_prd: enq1_old_prd, need_to_wb: enq1_need_to_wb};
        end
    end

    a_lane1_needs_lane0: assert property (@(posedge clock) disable iff (!reset_n)
        enq1_valid |-> enq0_valid);
    a_wb0_not_enqueuing: assert property (@(posedge clock) disable iff (!reset_n)
        wb0_valid |-> !((enq0_fire && wb0_robidx == enq_ptr.idx) || (enq1_fire && wb0_robidx == enq_ptr1.idx)));
    a_wb1_not_enqueuing: assert property (@(posedge clock) disable iff (!reset_n)
        wb1_valid |-> !((enq0_fire && wb1_robidx == enq_ptr.idx) || (enq1_fire && wb1_robidx == enq_ptr1.idx)));
endmodule

// File: tb/tb_reorder_buffer.sv
// tb_reorder_buffer: scoreboard bench for reorder_buffer with a small reference model.
module tb_reorder_buffer;
    import rob_pkg::*;

    typedef struct packed {
        logic [PC_W-1:0]   pc;
        logic [LREG_W-1:0] lrd;
        logic [PREG_W-1:0] prd;
        logic [PREG_W-1:0] old_prd;
        logic              need;
    } pay_t;

    logic clock = 1'b0, reset_n = 1'b0;
    logic enq0_valid = 0, enq1_valid = 0, enq0_ready, enq1_ready;
    logic [PC_W-1:0] enq0_pc = '0, enq1_pc = '0;
    logic [LREG_W-1:0] enq0_lrd = '0, enq1_lrd = '0;
    logic [PREG_W-1:0] enq0_prd = '0, enq0_old_prd = '0, enq1_prd = '0, enq1_old_prd = '0;
    logic enq0_need_to_wb = 0, enq1_need_to_wb = 0;
    logic [ROB_SIZE_LOG:0] counter;
    logic enq_robidx_flag;
    logic [ROB_SIZE_LOG-1:0] enq_robidx;
    logic wb0_valid = 0, wb1_valid = 0;
    logic [ROB_SIZE_LOG-1:0] wb0_robidx = '0, wb1_robidx = '0;
    logic commit0_valid, commit1_valid, commit0_need_to_wb, commit1_need_to_wb;
    logic [PC_W-1:0] commit0_pc, commit1_pc;
    logic [LREG_W-1:0] commit0_lrd, commit1_lrd;
    logic [PREG_W-1:0] commit0_prd, commit0_old_prd, commit1_prd, commit1_old_prd;
    logic flush_valid = 0;

    reorder_buffer dut (
        .clock(clock), .reset_n(reset_n),
        .enq0_valid(enq0_valid), .enq1_valid(enq1_valid),
        .enq0_ready(enq0_ready), .enq1_ready(enq1_ready),
        .enq0_pc(enq0_pc), .enq0_lrd(enq0_lrd), .enq0_prd(enq0_prd),
        .enq0_old_prd(enq0_old_prd), .enq0_need_to_wb(enq0_need_to_wb),
        .enq1_pc(enq1_pc), .enq1_lrd(enq1_lrd), .enq1_prd(enq1_prd),
        .enq1_old_prd(enq1_old_prd), .enq1_need_to_wb(enq1_need_to_wb),
        .counter(counter), .enq_robidx_flag(enq_robidx_flag), .enq_robidx(enq_robidx),
        .wb0_valid(wb0_valid), .wb0_robidx(wb0_robidx),
        .wb1_valid(wb1_valid), .wb1_robidx(wb1_robidx),
        .commit0_valid(commit0_valid), .commit0_pc(commit0_pc), .commit0_lrd(commit0_lrd),
        .commit0_prd(commit0_prd), .commit0_old_prd(commit0_old_prd),
        .commit0_need_to_wb(commit0_need_to_wb),
        .commit1_valid(commit1_valid), .commit1_pc(commit1_pc), .commit1_lrd(commit1_lrd),
        .commit1_prd(commit1_prd), .commit1_old_prd(commit1_old_prd),
        .commit1_need_to_wb(commit1_need_to_wb),
        .flush_valid(flush_valid)
    );

    always #5 clock = ~clock;

    int   checks = 0, errors = 0;
    pay_t sb[$];
    bit   m_val[ROB_SIZE], m_comp[ROB_SIZE];
    int   m_enq = 0, m_deq = 0, m_cnt = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h exp %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_clear();
        for (int i = 0; i < ROB_SIZE; i++) begin
            m_val[i]  = 0;
            m_comp[i] = 0;
        end
        m_enq = 0;
        m_deq = 0;
        m_cnt = 0;
        sb.delete();
    endtask

    task automatic check_commit(input string tag, input pay_t got);
        pay_t e;
        if (sb.size() == 0) begin
            check({tag, "_sb_empty"}, 1, 0);
        end else begin
            e = sb.pop_front();
            check({tag, "_pc"}, 64'(got.pc), 64'(e.pc));
            check({tag, "_regs"}, 64'({got.lrd, got.prd, got.old_prd, got.need}),
                  64'({e.lrd, e.prd, e.old_prd, e.need}));
        end
    endtask

    // One cycle: drive after the falling edge, check before the rising edge, then advance the model.
    task automatic step(input bit e0, input bit e1, input bit fl,
                        input bit w0, input int w0i, input bit w1, input int w1i);
        pay_t p0, p1;
        bit   rdy, c0, c1;
        int   d, d1, e;
        @(negedge clock);
        p0 = pay_t'({$urandom, $urandom, $urandom});
        p1 = pay_t'({$urandom, $urandom, $urandom});
        enq0_valid = e0; enq1_valid = e1; flush_valid = fl;
        {enq0_pc, enq0_lrd, enq0_prd, enq0_old_prd, enq0_need_to_wb} = p0;
        {enq1_pc, enq1_lrd, enq1_prd, enq1_old_prd, enq1_need_to_wb} = p1;
        wb0_valid = w0; wb0_robidx = ROB_SIZE_LOG'(w0i % ROB_SIZE);
        wb1_valid = w1; wb1_robidx = ROB_SIZE_LOG'(w1i % ROB_SIZE);
        #1;
        rdy = !fl && (m_cnt <= ROB_SIZE - 2);
        d   = m_deq % ROB_SIZE;
        d1  = (m_deq + 1) % ROB_SIZE;
        c0  = !fl && m_val[d] && m_comp[d];
        c1  = c0 && m_val[d1] && m_comp[d1];
        check("ready0", 64'(enq0_ready), 64'(rdy));
        check("ready1", 64'(enq1_ready), 64'(rdy));
        check("counter", 64'(counter), 64'(m_cnt));
        check("enq_idx", 64'(enq_robidx), 64'(m_enq % ROB_SIZE));
        check("enq_flag", 64'(enq_robidx_flag), 64'((m_enq / ROB_SIZE) % 2));
        check("commit0_valid", 64'(commit0_valid), 64'(c0));
        check("commit1_valid", 64'(commit1_valid), 64'(c1));
        if (c0) check_commit("commit0", {commit0_pc, commit0_lrd, commit0_prd, commit0_old_prd, commit0_need_to_wb});
        if (c1) check_commit("commit1", {commit1_pc, commit1_lrd, commit1_prd, commit1_old_prd, commit1_need_to_wb});
        @(posedge clock);
        if (fl) begin
            model_clear();
        end else begin
            if (w0 && m_val[w0i % ROB_SIZE]) m_comp[w0i % ROB_SIZE] = 1;
            if (w1 && m_val[w1i % ROB_SIZE]) m_comp[w1i % ROB_SIZE] = 1;
            if (c0) begin m_val[d] = 0; m_comp[d] = 0; m_deq++; m_cnt--; end
            if (c1) begin m_val[d1] = 0; m_comp[d1] = 0; m_deq++; m_cnt--; end
            if (e0 && rdy) begin
                e = m_enq % ROB_SIZE;
                m_val[e] = 1; m_comp[e] = 0; sb.push_back(p0); m_enq++; m_cnt++;
                if (e1) begin
                    e = m_enq % ROB_SIZE;
                    m_val[e] = 1; m_comp[e] = 0; sb.push_back(p1); m_enq++; m_cnt++;
                end
            end
            m_enq %= 2 * ROB_SIZE;
            m_deq %= 2 * ROB_SIZE;
        end
    endtask

    initial begin
        int prev, base;
        bit have_prev;
        model_clear();
        #3;
        check("rst_ready0", 64'(enq0_ready), 0);
        check("rst_ready1", 64'(enq1_ready), 0);
        check("rst_commit0", 64'(commit0_valid), 0);
        @(negedge clock);
        reset_n = 1;
        repeat (3) step(0, 0, 0, 0, 0, 0, 0);

        // Fill to capacity; the 33rd attempt is refused.
        repeat (33) step(1, 1, 0, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0, 0, 0);
        check("full_counter", 64'(counter), 64'(ROB_SIZE));
        check("full_flag", 64'(enq_robidx_flag), 1);
        check("full_idx", 64'(enq_robidx), 0);
        step(0, 0, 1, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0, 0, 0);

        // Out-of-order completion: B then A, both retire together.
        step(1, 1, 0, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0, 1, 1);
        step(0, 0, 0, 1, 0, 0, 0);
        step(0, 0, 0, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0, 0, 0);

        // Steady dual enqueue / dual retire across the index wrap.
        have_prev = 0;
        prev = 0;
        for (int i = 0; i < 80; i++) begin
            base = m_enq;
            step(1, 1, 0, have_prev, prev, have_prev, prev + 1);
            prev = base;
            have_prev = 1;
        end
        step(0, 0, 0, 1, prev, 1, prev + 1);
        repeat (3) step(0, 0, 0, 0, 0, 0, 0);

        // Flush with 10 entries, 4 of them complete but not at the head.
        base = m_enq;
        repeat (5) step(1, 1, 0, 0, 0, 0, 0);
        step(0, 0, 0, 1, base + 2, 1, base + 3);
        step(0, 0, 0, 1, base + 4, 1, base + 5);
        step(1, 1, 1, 1, base, 1, base + 1);
        step(0, 0, 0, 0, 0, 0, 0);
        check("flush_counter", 64'(counter), 0);
        check("flush_idx", 64'({enq_robidx_flag, enq_robidx}), 0);

        // Asynchronous reset mid-stream with 20 entries.
        base = m_enq;
        repeat (10) step(1, 1, 0, 0, 0, 0, 0);
        step(0, 0, 0, 1, base, 1, base + 1);
        @(negedge clock);
        enq0_valid = 0; enq1_valid = 0; wb0_valid = 0; wb1_valid = 0;
        #2 reset_n = 0;
        #1;
        check("arst_counter", 64'(counter), 0);
        check("arst_idx", 64'({enq_robidx_flag, enq_robidx}), 0);
        check("arst_ready", 64'({enq0_ready, enq1_ready}), 0);
        check("arst_commit", 64'({commit0_valid, commit1_valid}), 0);
        check("arst_payload", 64'(commit0_pc ^ commit1_pc), 0);
        model_clear();
        @(negedge clock);
        reset_n = 1;
        repeat (2) step(0, 0, 0, 0, 0, 0, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/reorder_buffer.md
# reorder_buffer

Reorder buffer receiving the dispatch stage's two-lane enqueue stream. It publishes the enqueue pointer (`enq_robidx_flag`/`enq_robidx`) and occupancy (`counter`) that dispatch stamps onto each instruction. It tracks writeback completion and retires up to two oldest completed entries per cycle, in order, to the rename/free-list commit path. It sits between dispatch (enqueue side) and the rename commit logic and writeback buses (completion side).

## Interface
- `ROB_SIZE`, 64, entry count; power of two, ≥4.
- `ROB_SIZE_LOG`, $clog2(ROB_SIZE), index width.

- `clock`  in  1  single clock.
- `reset_n`  in  1  asynchronous, active-low reset.
- `enq0_valid` / `enq1_valid`  in  1  lane enqueue request from dispatch.
- `enq0_ready` / `enq1_ready`  out  1  lane accept.
- `enqN_pc`  in  48  instruction PC, N=0/1.
- `enqN_lrd`  in  LREG  logical destination.
- `enqN_prd`, `enqN_old_prd`  in  PREG  new and previous physical destination.
- `enqN_need_to_wb`  in  1  entry writes a register.
- `counter`  out  ROB_SIZE_LOG+1  occupied entries.
- `enq_robidx_flag`  out  1  wrap flag of the enqueue pointer.
- `enq_robidx`  out  ROB_SIZE_LOG  enqueue index.
- `wbK_valid`, `wbK_robidx`  in  1, ROB_SIZE_LOG  completion mark, K=0/1.
- `commitN_valid`  out  1  lane retires this cycle.
- `commitN_pc`, `commitN_lrd`, `commitN_prd`, `commitN_old_prd`, `commitN_need_to_wb`  out  as enq  retiring payload.
- `flush_valid`  in  1  discard all entries.

## Operation
- Per entry: valid, complete, payload. Pointers `enq_ptr` and `deq_ptr` are {flag, idx}.
- Enqueue:
  - Both readies equal `!flush_valid && counter <= ROB_SIZE-2`. Conservative: same-cycle commits are not credited.
  - Lane0 writes entry `enq_ptr`. Lane1 writes `enq_ptr+1` and is legal only with lane0 (assert `enq1_valid -> enq0_valid`).
  - New entries have valid=1, complete=0.
  - `enq_ptr` advances by the number of fired lanes. The flag toggles when idx wraps past ROB_SIZE-1.
- Writeback: `wbK_valid` sets complete on entry `wbK_robidx`. It is ignored if the entry is invalid. Both ports may target any entries in the same cycle.
- Commit (no backpressure):
  - `commit0_valid = valid[deq] && complete[deq]`.
  - `commit1_valid = commit0_valid && valid[deq+1] && complete[deq+1]`.
  - Outputs are combinational from registered entry state.
  - Retired entries clear valid. `deq_ptr` advances by the number of retired lanes.
- Counter: next = counter + enq_fired − commits, computed in ROB_SIZE_LOG+1 bits. It never exceeds ROB_SIZE.
- Flush:
  - Next cycle, all valid/complete bits are cleared, both pointers are 0 with flag 0, and counter is 0.
  - Commit outputs are forced 0 and writebacks are ignored in the flush cycle.
- Empty: enq_ptr == deq_ptr with equal flags. Full: equal idx, differing flags, counter == ROB_SIZE.

## Timing
- Reset (asynchronous): pointers, flags, counter, and all valid/complete bits go to 0.
  - `enq0_ready`/`enq1_ready` are 0 while `reset_n` is low and 1 from the first cycle after release.
  - All `commit*_valid` outputs are 0; commit payload outputs are 0.
- Enqueue at edge N: `enq_robidx`/`counter` update after edge N, and the entry is valid in cycle N+1.
- Writeback at edge M makes complete visible at M+1. Earliest commit is in the cycle after the completing edge.
- Writeback to an entry in its own enqueue cycle is illegal (asserted).
- Writeback and commit of the same entry in one cycle: commit uses pre-edge state, so the entry retires the next cycle.
- Enqueue and commit in the same cycle are both applied. The enqueue must not overwrite an entry retiring that cycle; this is guaranteed by the ready rule.

## Structure
- Package `rob_pkg`: `rob_ptr_t` ({flag, idx}), `rob_entry_t` (valid, complete, pc, lrd, prd, old_prd, need_to_wb), constant ROB_SIZE.
- Sub-module `rob_ptr_add`: adds 0..2 to a `rob_ptr_t` with flag toggle on wrap. Instantiated for enq_ptr, enq_ptr+1, deq_ptr, and deq_ptr+1.

## Test plan
- Reset then idle → readies 1, counter 0, enq_robidx 0, flag 0, no commit.
- 32 dual enqueues with ROB_SIZE=64, no writebacks → counter 64, readies low after counter reaches 63, enq_robidx 0, flag 1.
- Enqueue A (idx0) and B (idx1); writeback B first, then A a cycle later → no commit until A completes, then A and B retire in one cycle on lanes 0/1 with correct prd/old_prd.
- Steady dual enqueue/dual retire across the idx 63→0 wrap → flag toggles, counter stable, commits in program order.
- Flush with 10 entries, 4 complete, plus a simultaneous enqueue → no commits that cycle, next cycle counter 0, pointers 0, enqueue dropped.
- Assert `reset_n` low mid-stream with 20 entries → outputs reset immediately, before any clock edge.
